tff_counter_ctrl: RTL and testbench

TFF_COUNTER_CTRL -- requirements
Module: tff_counter_ctrl

---
 rtl/tff_counter_ctrl_pkg.sv | 22 ++
 rtl/tff_counter_ctrl_tff.sv | 16 +
 rtl/tff_counter_ctrl.sv | 126 ++++++++++++
 tb/tb_tff_counter_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/tff_counter_ctrl_pkg.sv
// Shared definitions for the T-flip-flop counter controller: command opcodes,
// controller states and the default bank width.
package tff_counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_UP  = 2'b00,
    OP_DN  = 2'b01,
    OP_LD  = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_CLR   = 3'd2,
    ST_SET   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tff_counter_ctrl_tff.sv
// Single T flip-flop with asynchronous active-low reset and preset; reset wins.
module t_flip_flop (
  input  logic clk_i,
  input  logic rst_b_i,
  input  logic prt_b_i,
  input  logic t_i,
  output logic q_o
);

  always_ff @(posedge clk_i or negedge rst_b_i or negedge prt_b_i) begin
    if (!rst_b_i)      q_o <= 1'b0;
    else if (!prt_b_i) q_o <= 1'b1;
    else if (t_i)      q_o <= ~q_o;
  end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequencer for a bank of T flip-flops: counts up/down by N steps, loads or
// clears the bank through its async reset/preset lines.
//
// state | meaning
// IDLE  | ready for a command
// COUNT | one up/down step per cycle until steps_q runs out
// CLR   | bank reset lines active for one cycle
// SET   | preset lines active on the 1-bits of the load value
// DONE  | completion pulse, then back to IDLE
module tff_counter_ctrl
  import tff_counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] steps_q;
  logic             done_q;
  logic             wrap_q;
  logic             bank_rst_b_q;
  logic [WIDTH-1:0] bank_prt_b_q;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] t_en_d;
  logic             carry_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_UP;
      data_q       <= '0;
      steps_q      <= '0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      bank_rst_b_q <= 1'b0;
      bank_prt_b_q <= '1;
    end else begin
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      bank_rst_b_q <= 1'b1;
      bank_prt_b_q <= '1;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            op_q    <= op_e'(cmd_op_i);
            data_q  <= cmd_data_i;
            steps_q <= cmd_data_i;
            if (cmd_op_i == OP_LD || cmd_op_i == OP_CLR) begin
              state_q      <= ST_CLR;
              bank_rst_b_q <= 1'b0;
            end else if (cmd_data_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          steps_q <= steps_q - ONE;
          // wrap lands together with the wrapped count value
          wrap_q  <= (op_q == OP_UP) ? (bank_q == '1) : (bank_q == '0);
          if (steps_q == ONE) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_CLR: begin
          if (op_q == OP_LD) begin
            state_q      <= ST_SET;
            bank_prt_b_q <= ~data_q;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_SET: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ripple enable chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_en_d  = '0;
    carry_d = (state_q == ST_COUNT);
    for (int i = 0; i < WIDTH; i++) begin
      t_en_d[i] = carry_d;
      carry_d   = carry_d & ((op_q == OP_UP) ? bank_q[i] : ~bank_q[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    t_flip_flop u_tff (
      .clk_i   (clk_i),
      .rst_b_i (bank_rst_b_q),
      .prt_b_i (bank_prt_b_q[g]),
      .t_i     (t_en_d[g]),
      .q_o     (bank_q[g])
    );
  end

  assign count_o     = bank_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Randomized and directed bench for tff_counter_ctrl against a cycle-indexed
// arithmetic model of each command.
module tb_tff_counter_ctrl;

  localparam int W = 4;
  localparam int M = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [1:0]   cmd_op_i;
  logic [W-1:0] cmd_data_i;
  logic [W-1:0] count_o;
  logic         busy_o;
  logic         done_o;
  logic         wrap_o;

  int n_checks = 0;
  int n_errors = 0;
  int model_count = 0;

  tff_counter_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_data_i  (cmd_data_i),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // j counts cycles after the accepting edge; done lands at j==d, ready at j==d+1.
  task automatic run_cmd(input int op, input int data, input bit hold);
    int d;
    int exp_c;
    bit exp_w;
    exp_c = model_count;
    chk("ready_pre", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op[1:0];
    cmd_data_i  = data[W-1:0];
    step();
    if (hold) begin
      cmd_op_i   = 2'b10;
      cmd_data_i = 4'd7;
    end else begin
      cmd_valid_i = 1'b0;
    end
    d = (op < 2) ? data : ((op == 2) ? 2 : 1);
    for (int j = 0; j <= d; j++) begin
      if (op == 0)      exp_c = (model_count + j) % M;
      else if (op == 1) exp_c = ((model_count - j) % M + M) % M;
      else if (op == 2) exp_c = (j == 0) ? 0 : data;
      else              exp_c = 0;
      exp_w = (op == 0 && j > 0 && exp_c == 0) || (op == 1 && j > 0 && exp_c == M - 1);
      chk("count", count_o, exp_c);
      chk("done", done_o, (j == d) ? 1 : 0);
      chk("wrap", wrap_o, exp_w ? 1 : 0);
      chk("busy", busy_o, 1);
      chk("ready_busy", cmd_ready_o, 0);
      step();
    end
    model_count = exp_c;
    chk("count_end", count_o, model_count);
    chk("busy_end", busy_o, 0);
    chk("done_end", done_o, 0);
    chk("wrap_end", wrap_o, 0);
    chk("ready_end", cmd_ready_o, 1);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b00;
    cmd_data_i  = '0;
    step();
    chk("rst_count", count_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_wrap", wrap_o, 0);
    step();
    rst_i = 1'b0;
    #1;
    chk("rst_release_ready", cmd_ready_o, 1);
    model_count = 0;

    run_cmd(0, 5, 0);
    run_cmd(2, 14, 0);
    run_cmd(0, 3, 0);
    run_cmd(2, 1, 0);
    run_cmd(1, 2, 0);
    run_cmd(2, 5, 0);
    run_cmd(2, 10, 0);
    run_cmd(0, 0, 1);
    run_cmd(1, 3, 1);
    run_cmd(3, 0, 0);
    run_cmd(2, 6, 0);

    // reset during the third step of an 8-step up count
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b00;
    cmd_data_i  = 4'd8;
    step();
    cmd_valid_i = 1'b0;
    step();
    chk("abort_step1", count_o, (model_count + 1) % M);
    step();
    chk("abort_step2", count_o, (model_count + 2) % M);
    rst_i = 1'b1;
    step();
    chk("abort_count", count_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_ready_in_rst", cmd_ready_o, 0);
    rst_i = 1'b0;
    #1;
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_done2", done_o, 0);
    step();
    chk("abort_done3", done_o, 0);
    chk("abort_count2", count_o, 0);
    model_count = 0;

    for (int n = 0; n < 30; n++) begin
      run_cmd($urandom_range(0, 3), $urandom_range(0, M - 1), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
